// File: rtl/word_shift_out_if.sv
// Load-side and serial-side handshake bundle for word_shift_out.
// slave: D/LOAD_VALID/OUT_READY in; LOAD_READY/OUT_* /BIT_CNT out.
interface word_shift_out_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] D;
  logic             LOAD_VALID;
  logic             LOAD_READY;
  logic             OUT_BIT;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic             OUT_LAST;
  logic [4:0]       BIT_CNT;

  modport master (
    output D, LOAD_VALID, OUT_READY,
    input  LOAD_READY, OUT_BIT,
    input  OUT_VALID, OUT_LAST, BIT_CNT
  );

  modport slave (
    input  D, LOAD_VALID, OUT_READY,
    output LOAD_READY, OUT_BIT,
    output OUT_VALID, OUT_LAST, BIT_CNT
  );
endinterface

// File: rtl/word_shift_out.sv
// Parallel-to-serial unloader: CLK, RST (async high), bus (slave).
// MSB first; WORD_SHIFT_OUT_LSB_FIRST_EN selects LSB-first order.
module word_shift_out #(
  parameter int WIDTH = 32
) (
  input logic            CLK,
  input logic            RST,
  word_shift_out_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [4:0] LAST = 5'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_adv;
  logic             head;

  logic             load_ready;
  logic             out_bit;
  logic             out_valid;
  logic             out_last;
  logic [4:0]       bit_cnt;

`ifdef WORD_SHIFT_OUT_LSB_FIRST_EN
  assign head   = sr_q[0];
  assign sr_adv = {1'b0, sr_q[WIDTH-1:1]};
`else
  assign head   = sr_q[WIDTH-1];
  assign sr_adv = {sr_q[WIDTH-2:0], 1'b0};
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    load_ready = 1'b0;
    out_bit    = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    bit_cnt    = 5'd0;
    unique case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        if (bus.LOAD_VALID) begin
          sr_d    = bus.D;
          cnt_d   = 5'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        out_valid = 1'b1;
        out_bit   = head;
        out_last  = (cnt_q == LAST);
        bit_cnt   = cnt_q;
        if (bus.OUT_READY) begin
          sr_d = sr_adv;
          if (cnt_q == LAST) begin
            cnt_d   = 5'd0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.LOAD_READY = load_ready;
  assign bus.OUT_BIT    = out_bit;
  assign bus.OUT_VALID  = out_valid;
  assign bus.OUT_LAST   = out_last;
  assign bus.BIT_CNT    = bit_cnt;
endmodule

// File: tb/tb_word_shift_out.sv
// Self-checking bench for word_shift_out (WIDTH=32 and WIDTH=2).
// Random and directed words checked against a bit-index model.
module tb_word_shift_out;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  word_shift_out_if #(.WIDTH(32)) b32 ();
  word_shift_out_if #(.WIDTH(2))  b2 ();

  word_shift_out #(.WIDTH(32)) u32 (
    .CLK(CLK), .RST(RST), .bus(b32.slave)
  );
  word_shift_out #(.WIDTH(2)) u2 (
    .CLK(CLK), .RST(RST), .bus(b2.slave)
  );

  logic        sel;
  logic [31:0] d_r;
  logic        lv_r;
  logic        ordy_r;

  assign b32.D          = d_r;
  assign b32.LOAD_VALID = lv_r & ~sel;
  assign b32.OUT_READY  = ordy_r;
  assign b2.D           = d_r[1:0];
  assign b2.LOAD_VALID  = lv_r & sel;
  assign b2.OUT_READY   = ordy_r;

  wire       o_lr = sel ? b2.LOAD_READY : b32.LOAD_READY;
  wire       o_ob = sel ? b2.OUT_BIT    : b32.OUT_BIT;
  wire       o_ov = sel ? b2.OUT_VALID  : b32.OUT_VALID;
  wire       o_ol = sel ? b2.OUT_LAST   : b32.OUT_LAST;
  wire [4:0] o_bc = sel ? b2.BIT_CNT    : b32.BIT_CNT;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [31:0] w,
                                   input int wd,
                                   input int i);
`ifdef WORD_SHIFT_OUT_LSB_FIRST_EN
    return w[i];
`else
    return w[wd-1-i];
`endif
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_lr"}, o_lr, 1);
    chk({tag, "_ov"}, o_ov, 0);
    chk({tag, "_ol"}, o_ol, 0);
    chk({tag, "_bc"}, o_bc, 0);
    chk({tag, "_ob"}, o_ob, 0);
  endtask

  // Called at a negedge with the selected DUT idle.
  task automatic send_word(input logic [31:0] w,
                           input int wd,
                           input int stall_pct,
                           input int stall_first,
                           input bit hold_next,
                           input logic [31:0] nextw,
                           output int unsigned load_cyc);
    int i;
    int guard;
    int stalls;
    i = 0;
    guard = 0;
    stalls = stall_first;
    chk_idle("pre_load");
    d_r = w;
    lv_r = 1'b1;
    ordy_r = 1'($urandom_range(0, 1));
    load_cyc = cyc + 1;
    @(negedge CLK);
    while (i < wd && guard < 2000) begin
      chk("valid", o_ov, 1);
      chk("ready_lo", o_lr, 0);
      chk("bit", o_ob, exp_bit(w, wd, i));
      chk("cnt", o_bc, i);
      chk("last", o_ol, (i == wd - 1));
      if (hold_next) begin
        lv_r = 1'b1;
        d_r = nextw;
      end else begin
        lv_r = 1'($urandom_range(0, 1));
        d_r = $urandom;
      end
      if (stalls > 0) begin
        ordy_r = 1'b0;
        stalls--;
      end else begin
        ordy_r = ($urandom_range(0, 99) >= stall_pct);
      end
      @(negedge CLK);
      if (ordy_r) i++;
      guard++;
    end
    if (i < wd) chk("timeout", i, wd);
    lv_r = hold_next;
    if (hold_next) d_r = nextw;
    chk("post_lr", o_lr, 1);
    chk("post_ov", o_ov, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned lc1, lc2;
    logic [31:0] w;
    sel = 1'b0;
    d_r = '0;
    lv_r = 1'b0;
    ordy_r = 1'b0;
    repeat (2) @(negedge CLK);
    chk_idle("reset");
    RST = 1'b0;

    send_word(32'hA5000001, 32, 0, 0, 0, 0, lc1);
    send_word(32'h80000000, 32, 0, 5, 0, 0, lc1);

    send_word(32'hFFFFFFFF, 32, 0, 0, 1, 0, lc1);
    send_word(32'h00000000, 32, 0, 0, 0, 0, lc2);
    chk("b2b_gap32", lc2 - lc1, 33);

    repeat (6) begin
      w = $urandom;
      send_word(w, 32, 30, 0, 0, 0, lc1);
    end

    w = $urandom;
    send_word($urandom, 32, 0, 0, 1, w, lc1);
    send_word(w, 32, 20, 0, 0, 0, lc2);
    chk("b2b_rand_gap", lc2 >= lc1 + 33, 1);

    d_r = 32'hFFFFFFFF;
    lv_r = 1'b1;
    ordy_r = 1'b1;
    @(negedge CLK);
    lv_r = 1'b0;
    repeat (10) @(negedge CLK);
    chk("mid_cnt", o_bc, 10);
    chk("mid_ov", o_ov, 1);
    ordy_r = 1'b0;
    #2 RST = 1'b1;
    #1 chk_idle("async_rst");
    @(negedge CLK);
    RST = 1'b0;
    ordy_r = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk_idle("post_rst");
    end

    w = $urandom;
    send_word(w, 32, 25, 0, 0, 0, lc1);

    sel = 1'b1;
    @(negedge CLK);
    send_word(32'h2, 2, 0, 0, 0, 0, lc1);
    repeat (4) begin
      w = $urandom;
      send_word(w, 2, 40, 0, 0, 0, lc1);
    end
    send_word(32'h1, 2, 0, 0, 1, 32'h3, lc1);
    send_word(32'h3, 2, 0, 0, 0, 0, lc2);
    chk("b2b_gap2", lc2 - lc1, 3);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
